// File: rtl/nios_system_sysid_ext_if.sv
// Avalon-MM bus bundle for the sysid slave: word address, read/write strobes, byte lanes
// and the pipelined read-return pair (readdata/readdatavalid). No waitrequest.
interface nios_system_sysid_ext_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/nios_system_sysid_ext.sv
// System-ID / build-info Avalon slave with 64-bit uptime, atomic lo/hi snapshot and READ_LATENCY read pipe.
// Define NIOS_SYSTEM_SYSID_SCRATCH_EN to build NUM_SCRATCH RW scratch words at 6..; otherwise they read 0.
module nios_system_sysid_ext #(
  parameter logic [31:0] SYSTEM_ID    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd1513181670,
  parameter int          ADDR_W       = 4,
  parameter int          READ_LATENCY = 1,
  parameter int          TICK_DIV     = 1,
  parameter int          NUM_SCRATCH  = 2
) (
  input  logic                          clock,
  input  logic                          reset_n,
  nios_system_sysid_ext_if.slave        avs
);

`ifdef NIOS_SYSTEM_SYSID_SCRATCH_EN
  localparam int   NS_EFF      = NUM_SCRATCH;
  localparam logic SCR_PRESENT = 1'b1;
`else
  localparam int   NS_EFF      = 0;
  localparam logic SCR_PRESENT = 1'b0;
`endif
  localparam logic [15:0] PRESC_TC = 16'(TICK_DIV - 1);
  localparam logic [31:0] CAPS     = {8'h01, 4'(READ_LATENCY), 4'h0, 8'(NS_EFF), 7'h0, SCR_PRESENT};

  logic [63:0] uptime_q, uptime_d;
  logic [15:0] presc_q, presc_d;
  logic [31:0] snap_q, snap_d;
  logic [31:0] rd_sel;
  logic [31:0] dat_q [READ_LATENCY];
  logic [READ_LATENCY-1:0] vld_q;
  logic        lo_rd, lo_wr;

  assign lo_rd = avs.read  && (avs.address == ADDR_W'(3));
  assign lo_wr = avs.write && (avs.address == ADDR_W'(3));

  // Clear beats increment; snapshot takes hi from the same (pre-edge) uptime that supplies lo.
  always_comb begin
    uptime_d = uptime_q;
    presc_d  = presc_q + 16'd1;
    if (lo_wr) begin
      uptime_d = '0;
      presc_d  = '0;
    end else if (presc_q == PRESC_TC) begin
      uptime_d = uptime_q + 64'd1;
      presc_d  = '0;
    end
    snap_d = lo_rd ? uptime_q[63:32] : snap_q;
  end

`ifdef NIOS_SYSTEM_SYSID_SCRATCH_EN
  localparam int NS_ARR = (NUM_SCRATCH > 0) ? NUM_SCRATCH : 1;
  logic [31:0] scratch_q [NS_ARR];
  logic [31:0] scratch_d [NS_ARR];

  always_comb begin
    for (int i = 0; i < NS_ARR; i++) begin
      scratch_d[i] = scratch_q[i];
      for (int b = 0; b < 4; b++) begin
        if (i < NUM_SCRATCH && avs.write && avs.byteenable[b] && avs.address == ADDR_W'(6 + i))
          scratch_d[i][8*b +: 8] = avs.writedata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS_ARR; i++) scratch_q[i] <= '0;
    end else begin
      for (int i = 0; i < NS_ARR; i++) scratch_q[i] <= scratch_d[i];
    end
  end
`else
  logic unused_wr;
  assign unused_wr = ^{avs.writedata, avs.byteenable};
`endif

  always_comb begin
    rd_sel = '0;
    case (avs.address)
      ADDR_W'(0): rd_sel = SYSTEM_ID;
      ADDR_W'(1): rd_sel = TIMESTAMP;
      ADDR_W'(2): rd_sel = CAPS;
      ADDR_W'(3): rd_sel = uptime_q[31:0];
      ADDR_W'(4): rd_sel = snap_q;
      ADDR_W'(5): rd_sel = 32'(TICK_DIV);
      default:    rd_sel = '0;
    endcase
`ifdef NIOS_SYSTEM_SYSID_SCRATCH_EN
    for (int i = 0; i < NUM_SCRATCH; i++) begin
      if (avs.address == ADDR_W'(6 + i)) rd_sel = scratch_q[i];
    end
`endif
  end

  // Data stages only load behind a valid, so the last stage holds the previous result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q <= '0;
      presc_q  <= '0;
      snap_q   <= '0;
      vld_q    <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      uptime_q <= uptime_d;
      presc_q  <= presc_d;
      snap_q   <= snap_d;
      vld_q[0] <= avs.read;
      if (avs.read) dat_q[0] <= rd_sel;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign avs.readdata      = dat_q[READ_LATENCY-1];
  assign avs.readdatavalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_nios_system_sysid_ext.sv
// Directed + random bench for nios_system_sysid_ext with a cycle-count based uptime model
// and an in-order expected-return queue checked on every falling edge.
module tb_nios_system_sysid_ext;
  localparam int          AW  = 4;
  localparam int          RL  = 3;
  localparam int          TD  = 4;
  localparam int          NS  = 2;
  localparam logic [31:0] SID = 32'h0000_0000;
  localparam logic [31:0] TS  = 32'd1513181670;
`ifdef NIOS_SYSTEM_SYSID_SCRATCH_EN
  localparam bit SCR = 1'b1;
`else
  localparam bit SCR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  nios_system_sysid_ext_if #(.ADDR_W(AW)) bus ();

  nios_system_sysid_ext #(
    .SYSTEM_ID(SID), .TIMESTAMP(TS), .ADDR_W(AW),
    .READ_LATENCY(RL), .TICK_DIV(TD), .NUM_SCRATCH(NS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .avs     (bus)
  );

  typedef struct {
    int          due;
    logic [31:0] dat;
  } exp_t;

  int              total = 0;
  int              bad   = 0;
  int              cyc   = 0;
  longint unsigned edges = 0;   // clocks since last reset release or uptime clear
  logic [31:0]     m_snap = '0;
  logic [31:0]     last_dat = '0;
  logic [31:0]     m_scr [NS];
  exp_t            q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input int a);
    longint unsigned up;
    up = edges / 64'(TD);
    case (a)
      0: return SID;
      1: return TS;
      2: return 32'h0100_0000 | 32'(RL << 20) | (SCR ? 32'((NS << 8) | 1) : 32'h0);
      3: return up[31:0];
      4: return m_snap;
      5: return 32'(TD);
      default: begin
        if (SCR && a >= 6 && a < 6 + NS) return m_scr[a-6];
        return 32'h0;
      end
    endcase
  endfunction

  // Drive one bus cycle from a falling edge, advance the model at the rising edge,
  // then check outputs at the next falling edge.
  task automatic step(input bit rd, input bit wr, input int a, input logic [31:0] wd, input logic [3:0] be);
    exp_t e;
    longint unsigned up;
    bus.read = rd; bus.write = wr; bus.address = AW'(a);
    bus.writedata = wd; bus.byteenable = be;
    if (rd) begin
      e.due = cyc + RL;
      e.dat = model_read(a);
      q.push_back(e);
      if (a == 3) begin
        up = edges / 64'(TD);
        m_snap = up[63:32];
      end
    end
    @(posedge clock);
    if (!reset_n) edges = 0;
    else if (wr && a == 3) edges = 0;
    else edges++;
    if (reset_n && wr && SCR) begin
      for (int i = 0; i < NS; i++)
        if (a == 6 + i)
          for (int b = 0; b < 4; b++)
            if (be[b]) m_scr[i][8*b +: 8] = wd[8*b +: 8];
    end
    @(negedge clock);
    cyc++;
    if (!reset_n) begin
      chk("rst_rdv", 32'(bus.readdatavalid), 32'h0);
      chk("rst_rdata", bus.readdata, 32'h0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rdv", 32'(bus.readdatavalid), 32'h1);
      chk("rdata", bus.readdata, e.dat);
      last_dat = e.dat;
    end else begin
      chk("no_rdv", 32'(bus.readdatavalid), 32'h0);
      chk("hold", bus.readdata, last_dat);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 32'h0, 4'h0);
  endtask

  task automatic assert_reset();
    reset_n = 1'b0;
    q.delete();
    edges = 0;
    m_snap = '0;
    last_dat = '0;
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
  endtask

  initial begin
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.byteenable = '0;
    for (int i = 0; i < NS; i++) m_scr[i] = '0;
    @(negedge clock);
    @(negedge clock);
    chk("reset_rdv", 32'(bus.readdatavalid), 32'h0);
    chk("reset_rdata", bus.readdata, 32'h0);
    reset_n = 1'b1;

    // ID words back to back
    step(1, 0, 0, 32'h0, 4'h0);
    step(1, 0, 1, 32'h0, 4'h0);
    step(1, 0, 2, 32'h0, 4'h0);
    idle(RL + 2);
    step(1, 0, 5, 32'h0, 4'h0);
    idle(RL);

    // uptime after clear and 40 clocks -> 10 ticks
    step(0, 1, 3, 32'h1234_5678, 4'hF);
    idle(40);
    step(1, 0, 3, 32'h0, 4'h0);
    step(1, 0, 4, 32'h0, 4'h0);
    idle(RL);

    // read and clear of word 3 in the same cycle
    idle(9);
    step(1, 1, 3, 32'hDEAD_BEEF, 4'hF);
    step(1, 0, 3, 32'h0, 4'h0);
    idle(RL);

    // scratch byte lanes
    step(0, 1, 6, 32'hA5A5_A5A5, 4'b0101);
    step(1, 0, 6, 32'h0, 4'h0);
    step(0, 1, 7, 32'hFFFF_FFFF, 4'b0000);
    step(1, 0, 7, 32'h0, 4'h0);
    idle(RL);

    // unmapped read, write to RO id word
    step(1, 0, 15, 32'h0, 4'h0);
    step(0, 1, 0, 32'hFFFF_FFFF, 4'hF);
    step(1, 0, 0, 32'h0, 4'h0);
    idle(RL);

    // reset while a read is in flight
    step(1, 0, 1, 32'h0, 4'h0);
    assert_reset();
    chk("async_rst_rdv", 32'(bus.readdatavalid), 32'h0);
    chk("async_rst_rdata", bus.readdata, 32'h0);
    idle(2);
    reset_n = 1'b1;
    idle(RL + 2);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0),
           int'($urandom_range(15, 0)), 32'($urandom), 4'($urandom_range(15, 0)));
    end
    idle(RL + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nios_system_sysid_ext.md
Name: nios_system_sysid_ext

Overview:
Parametrised system-ID and build-information slave on the Nios II Avalon-MM fabric. Returns a fixed system ID, a build timestamp and a capability word. Also provides:
- a free-running 64-bit uptime counter with atomic hi/lo snapshot;
- a software-clearable uptime;
- optional scratch registers.
Read data is returned after a configurable pipelined latency, signalled by readdatavalid.

Parameters:
SYSTEM_ID, 32'h0000_0000, value returned at word 0
TIMESTAMP, 32'd1513181670, build timestamp returned at word 1
ADDR_W, 4, word-address width (minimum 3)
READ_LATENCY, 1, cycles from accepted read to readdatavalid; legal 1..4
TICK_DIV, 1, uptime increments once every TICK_DIV clocks; legal 1..65535
NUM_SCRATCH, 2, scratch registers at words 6..6+NUM_SCRATCH-1; legal 0..(2^ADDR_W-6)

Ports:
clock  in  1  single clock
reset_n  in  1  asynchronous, active-low reset
address  in  ADDR_W  word address
read  in  1  read strobe, one request per asserted cycle
write  in  1  write strobe
writedata  in  32  write data
byteenable  in  4  byte lanes for write
readdata  out  32  read data, valid only with readdatavalid
readdatavalid  out  1  one-cycle pulse per accepted read

Behaviour:
- Reset values:
  - readdata=0, readdatavalid=0;
  - uptime=0, prescaler=0, snapshot=0;
  - scratch=0;
  - all pipeline stages cleared.
- No waitrequest: every read/write is accepted in the cycle it is asserted. Back-to-back reads every cycle are legal.
- Register map (word address):
  - 0 SYSTEM_ID (RO).
  - 1 TIMESTAMP (RO).
  - 2 CAPS (RO) = {8'h01 version, 4'(READ_LATENCY), 4'h0, 8'(NUM_SCRATCH), 7'h0, scratch_present}.
  - 3 UPTIME_LO (RO read; a write of any data clears uptime and prescaler).
  - 4 UPTIME_HI_SNAP (RO).
  - 5 TICK_DIV (RO, zero-extended).
  - 6.. SCRATCH[n] (RW).
  - Unmapped addresses read 0; writes to them are ignored.
- Read path:
  - Data is selected in the accept cycle, then shifted through READ_LATENCY registers.
  - readdatavalid and readdata appear exactly READ_LATENCY cycles after read was high.
  - Results are returned in order.
  - readdata holds its last value when readdatavalid=0.
- Uptime:
  - The prescaler counts 0..TICK_DIV-1.
  - On the prescaler terminal count, uptime += 1 (64-bit) and the prescaler returns to 0.
  - With TICK_DIV=1, uptime increments every clock.
  - uptime wraps from 2^64-1 to 0; no flag.
- Snapshot:
  - A read of word 3 returns uptime[31:0] as of the accept cycle.
  - In the same cycle, uptime[63:32] is latched into the snapshot register.
  - A read of word 4 returns the snapshot, not live hi, so the lo-then-hi pair is atomic.
  - A lo read coinciding with a carry into hi captures the pre-increment hi, consistent with the returned lo.
- Clear:
  - A write to word 3 sets uptime=0 and prescaler=0 on the next edge; the clear has priority over the increment.
  - The snapshot is not cleared.
- Simultaneous read and write in one cycle:
  - The write takes effect.
  - The read returns the pre-write value.
  - A read of word 3 together with a write to word 3 returns the old lo, latches the old hi, then clears.
- Scratch writes apply per byteenable bit; a write with byteenable=0 changes nothing.
- Reset asserted mid-operation:
  - In-flight reads are discarded; no readdatavalid pulses after reset.
  - All state returns to reset values asynchronously.

Optional Feature:
Macro NIOS_SYSTEM_SYSID_SCRATCH_EN.
- Defined: NUM_SCRATCH scratch registers are implemented; CAPS[0]=1.
- Undefined:
  - no scratch storage is built;
  - words 6.. read 0 and writes to them are ignored;
  - CAPS[0]=0 and CAPS[15:8]=0 regardless of NUM_SCRATCH.

Test Plan:
- Reset, then READ_LATENCY=3, reads of words 0,1,2 on consecutive cycles -> readdatavalid high on cycles 3,4,5 after the first read, data 0x00000000, 1513181670, 0x01300000|(NUM_SCRATCH<<8)|scratch_present; no other pulses.
- TICK_DIV=4, run 40 clocks, read word 3 -> lo=10 (±1 for the sampling edge); preload uptime to 0x00000000_FFFFFFFF, read word 3 on the carry cycle -> lo=0xFFFFFFFF, then word 4 -> 0.
- Write 0xDEADBEEF to word 3 while reading word 3 -> read returns the old lo; the next read of word 3 returns ≤1.
- With macro: write 0xA5A5A5A5 to word 6 with byteenable=0101, after scratch=0 -> read 0x00A500A5. Without macro: same write, then read -> 0.
- Issue a read, then assert reset_n=0 one cycle later for 2 cycles -> no readdatavalid pulse; all outputs are 0 during reset.
- Read address 15 (unmapped) -> readdatavalid with data 0; a write to address 0 followed by a read of address 0 -> SYSTEM_ID unchanged.
